// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to the draw pipeline.
interface vga_timing_if #(
  parameter int CNT_W = 11
);
  logic [CNT_W-1:0] hcount;
  logic             hsync;
  logic             hblnk;
  logic [CNT_W-1:0] vcount;
  logic             vsync;
  logic             vblnk;
  logic             frame_start;

  modport master (
    output hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start
  );

  modport slave (
    input  hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 1024x768@60 raster timing generator: registered counters, sync/blank strobes
// and a start-of-frame pulse, all aligned to the counter values they describe.
module vga_timing_gen #(
  parameter int HOR_PIXELS     = 1024,
  parameter int HOR_SYNC_START = 1048,
  parameter int HOR_SYNC_STOP  = 1183,
  parameter int HOR_TOTAL      = 1344,
  parameter int VER_PIXELS     = 768,
  parameter int VER_SYNC_START = 771,
  parameter int VER_SYNC_STOP  = 776,
  parameter int VER_TOTAL      = 806,
  parameter int CNT_W          = 11
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  generate
    if (HOR_SYNC_STOP < HOR_SYNC_START || HOR_SYNC_START >= HOR_TOTAL ||
        HOR_SYNC_STOP >= HOR_TOTAL || HOR_PIXELS >= HOR_TOTAL) begin : g_bad_hor
      $error("vga_timing_gen: horizontal timing parameters out of range");
    end
    if (VER_SYNC_STOP < VER_SYNC_START || VER_SYNC_START >= VER_TOTAL ||
        VER_SYNC_STOP >= VER_TOTAL || VER_PIXELS >= VER_TOTAL) begin : g_bad_ver
      $error("vga_timing_gen: vertical timing parameters out of range");
    end
    if ((64'd1 << CNT_W) < 64'(HOR_TOTAL) || (64'd1 << CNT_W) < 64'(VER_TOTAL)) begin : g_bad_w
      $error("vga_timing_gen: CNT_W too narrow for the raster");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HOR_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VER_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(HOR_PIXELS);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(VER_PIXELS);
  localparam logic [CNT_W-1:0] H_SS    = CNT_W'(HOR_SYNC_START);
  localparam logic [CNT_W-1:0] H_SP    = CNT_W'(HOR_SYNC_STOP);
  localparam logic [CNT_W-1:0] V_SS    = CNT_W'(VER_SYNC_START);
  localparam logic [CNT_W-1:0] V_SP    = CNT_W'(VER_SYNC_STOP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] hcount_p0, vcount_p0;
  logic [CNT_W-1:0] hcount_nxt, vcount_nxt;
  logic             hsync_p0, hblnk_p0, vsync_p0, vblnk_p0, frame_start_p0;
  logic             hsync_nxt, hblnk_nxt, vsync_nxt, vblnk_nxt, frame_start_nxt;
  logic             h_wrap;

  // Strobes are derived from the next counter values so they land in the
  // same cycle as the counters they describe.
  always_comb begin
    h_wrap          = (hcount_p0 == H_LAST);
    hcount_nxt      = h_wrap ? '0 : hcount_p0 + CNT_ONE;
    vcount_nxt      = vcount_p0;
    frame_start_nxt = 1'b0;
    if (h_wrap) begin
      if (vcount_p0 == V_LAST) begin
        vcount_nxt      = '0;
        frame_start_nxt = 1'b1;
      end else begin
        vcount_nxt = vcount_p0 + CNT_ONE;
      end
    end
    hsync_nxt = (hcount_nxt >= H_SS) && (hcount_nxt <= H_SP);
    hblnk_nxt = (hcount_nxt >= H_VIS);
    vsync_nxt = (vcount_nxt >= V_SS) && (vcount_nxt <= V_SP);
    vblnk_nxt = (vcount_nxt >= V_VIS);
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_p0      <= '0;
      vcount_p0      <= '0;
      hsync_p0       <= 1'b0;
      hblnk_p0       <= 1'b0;
      vsync_p0       <= 1'b0;
      vblnk_p0       <= 1'b0;
      frame_start_p0 <= 1'b0;
    end else begin
      hcount_p0      <= hcount_nxt;
      vcount_p0      <= vcount_nxt;
      hsync_p0       <= hsync_nxt;
      hblnk_p0       <= hblnk_nxt;
      vsync_p0       <= vsync_nxt;
      vblnk_p0       <= vblnk_nxt;
      frame_start_p0 <= frame_start_nxt;
    end
  end

  assign vga.hcount      = hcount_p0;
  assign vga.vcount      = vcount_p0;
  assign vga.hsync       = hsync_p0;
  assign vga.hblnk       = hblnk_p0;
  assign vga.vsync       = vsync_p0;
  assign vga.vblnk       = vblnk_p0;
  assign vga.frame_start = frame_start_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster; expectations come from the
// number of clock edges since reset release, using division and modulo.
module tb_vga_timing_gen;

  localparam int HP    = 40;
  localparam int HSS   = 44;
  localparam int HSP   = 51;
  localparam int HT    = 60;
  localparam int VP    = 30;
  localparam int VSS   = 32;
  localparam int VSP   = 35;
  localparam int VT    = 40;
  localparam int CW    = 11;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_timing_if #(.CNT_W(CW)) vif ();

  vga_timing_gen #(
    .HOR_PIXELS(HP), .HOR_SYNC_START(HSS), .HOR_SYNC_STOP(HSP), .HOR_TOTAL(HT),
    .VER_PIXELS(VP), .VER_SYNC_START(VSS), .VER_SYNC_STOP(VSP), .VER_TOTAL(VT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;
  int prev_fs  = -1;
  int hs_cnt   = 0;
  int vs_cnt   = 0;
  int bl_cnt   = 0;
  int fs_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hcount"}, 32'(vif.hcount), 0);
    chk({tag, "_vcount"}, 32'(vif.vcount), 0);
    chk({tag, "_hsync"},  32'(vif.hsync), 0);
    chk({tag, "_hblnk"},  32'(vif.hblnk), 0);
    chk({tag, "_vsync"},  32'(vif.vsync), 0);
    chk({tag, "_vblnk"},  32'(vif.vblnk), 0);
    chk({tag, "_fstart"}, 32'(vif.frame_start), 0);
  endtask

  // Reference: t edges after release put the raster at pixel t mod (HT*VT).
  task automatic step();
    int h, v;
    bit e_hs, e_hb, e_vs, e_vb, e_fs;
    @(posedge clk);
    #1;
    t++;
    h    = t % HT;
    v    = (t / HT) % VT;
    e_hs = (h >= HSS) && (h <= HSP);
    e_hb = (h >= HP);
    e_vs = (v >= VSS) && (v <= VSP);
    e_vb = (v >= VP);
    e_fs = (t % FRAME) == 0;
    chk("hcount", 32'(vif.hcount), 32'(h));
    chk("vcount", 32'(vif.vcount), 32'(v));
    chk("hsync",  32'(vif.hsync),  32'(e_hs));
    chk("hblnk",  32'(vif.hblnk),  32'(e_hb));
    chk("vsync",  32'(vif.vsync),  32'(e_vs));
    chk("vblnk",  32'(vif.vblnk),  32'(e_vb));
    chk("frame_start", 32'(vif.frame_start), 32'(e_fs));
    if (t <= FRAME) begin
      hs_cnt += int'(vif.hsync);
      vs_cnt += int'(vif.vsync);
      bl_cnt += int'(vif.hblnk | vif.vblnk);
    end
    if (vif.frame_start === 1'b1) begin
      fs_cnt++;
      if (prev_fs >= 0) chk("fs_period", 32'(t - prev_fs), 32'(FRAME));
      prev_fs = t;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst     = 1'b0;
    t       = 0;
    prev_fs = -1;
  endtask

  initial begin
    int n_run, n_hold;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("cold_rst");
    release_rst();

    // Three full frames from a clean start: duty cycles and frame pulse period.
    repeat (3 * FRAME + 17) step();
    chk("hsync_duty", 32'(hs_cnt), 32'((HSP - HSS + 1) * VT));
    chk("vsync_duty", 32'(vs_cnt), 32'((VSP - VSS + 1) * HT));
    chk("blank_duty", 32'(bl_cnt), 32'(FRAME - HP * VP));
    chk("fs_count",   32'(fs_cnt), 3);

    // Asynchronous resets dropped at random points mid-frame.
    for (int k = 0; k < 4; k++) begin
      n_run  = $urandom_range(50, FRAME + 200);
      n_hold = $urandom_range(0, 3);
      repeat (n_run) step();
      #3;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      for (int j = 0; j < n_hold; j++) begin
        @(posedge clk);
        #1;
        chk_zero("held_rst");
      end
      release_rst();
      fs_cnt = 0;
      repeat (HT + 5) step();
      chk("no_early_fs", 32'(fs_cnt), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the 1024x768@60 Hz VGA raster timing from the 65 MHz pixel clock.
- Drives horizontal/vertical counters, sync and blanking strobes, and a start-of-frame pulse into the draw pipeline.
- Its hsync/vsync ultimately reach the board Hsync/Vsync pins and the frame-capture bench.
- Total raster is 1344 x 806 pixel periods.

Parameters:
- HOR_PIXELS, 1024, visible pixels per line
- HOR_SYNC_START, 1048, first hcount with hsync asserted
- HOR_SYNC_STOP, 1183, last hcount with hsync asserted
- HOR_TOTAL, 1344, pixel periods per line
- VER_PIXELS, 768, visible lines per frame
- VER_SYNC_START, 771, first vcount with vsync asserted
- VER_SYNC_STOP, 776, last vcount with vsync asserted
- VER_TOTAL, 806, lines per frame
- CNT_W, 11, counter width; must satisfy 2^CNT_W >= max(HOR_TOTAL, VER_TOTAL)

Ports:
- clk  input  1  pixel clock, 65 MHz
- rst  input  1  reset; asynchronous, active-high
- hcount  output  CNT_W  current pixel column, 0..HOR_TOTAL-1
- hsync  output  1  high while HOR_SYNC_START <= hcount <= HOR_SYNC_STOP
- hblnk  output  1  high while hcount >= HOR_PIXELS
- vcount  output  CNT_W  current line, 0..VER_TOTAL-1
- vsync  output  1  high while VER_SYNC_START <= vcount <= VER_SYNC_STOP
- vblnk  output  1  high while vcount >= VER_PIXELS
- frame_start  output  1  one-cycle pulse on the first pixel of every frame after reset

Behaviour:
- All outputs are registered; no combinational path from counters to outputs.
- Strobes are computed from next-state counter values, so every strobe is consistent with the hcount/vcount presented in the same cycle (zero relative latency).
- Reset, asynchronous and active-high: hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0, frame_start=0. All are held while rst=1.
- First rising edge after rst deasserts: hcount=1, vcount=0.
- Horizontal counter: increments every clk. When hcount==HOR_TOTAL-1 it wraps to 0 on the next edge.
- Vertical counter: increments only on the edge where hcount wraps.
  - When vcount==VER_TOTAL-1 and hcount wraps, vcount wraps to 0 together with hcount.
  - vcount changes only in the cycle hcount becomes 0.
- Sync windows are inclusive on both ends (START and STOP).
  - hsync is high for exactly HOR_SYNC_STOP-HOR_SYNC_START+1 = 136 cycles per line.
  - vsync is high for exactly 6 lines = 8064 cycles per frame.
- Both syncs are active-high here; any polarity inversion for the VESA mode is done at the board top, not in this block.
- Blanking:
  - hblnk is high for hcount 1024..1343 (320 cycles per line).
  - vblnk is high for vcount 768..805 (38 lines).
  - vblnk changes only when hcount becomes 0.
- frame_start is 1 in exactly the cycle where (hcount,vcount) becomes (0,0) from a wrap of (HOR_TOTAL-1, VER_TOTAL-1). It is not asserted for the post-reset (0,0).
- Period: frame_start pulses every HOR_TOTAL*VER_TOTAL = 1,083,264 cycles. vsync rising edges are spaced by the same amount.
- Reset mid-frame: all outputs return to reset values immediately, independent of clk. Timing restarts from (0,0) as from cold reset, with no partial pulse retained.
- Counters never reach HOR_TOTAL or VER_TOTAL; no illegal states exist.
- Out-of-range parameters (STOP < START, or START >= TOTAL) are rejected by an elaboration-time check.

Test Plan:
- Reset check: assert rst mid-line (e.g. at hcount=500, vcount=300) asynchronously between edges. Expect all outputs at 0 before the next clk edge, and hcount=1, vcount=0 one edge after release.
- Horizontal timing: run one line and sample per cycle.
  - hblnk rises at hcount=1024.
  - hsync is high at hcount=1048 and hcount=1183, and low at hcount=1047 and hcount=1184.
  - hcount goes 1343->0 with vcount incrementing by 1 in that same cycle.
- Vertical timing: run one frame.
  - vblnk rises with (hcount=0, vcount=768).
  - vsync is high for vcount 771..776 only.
  - vcount goes 805->0 at the hcount wrap.
- Frame pulse: no frame_start in the first frame after reset. Expect a single-cycle frame_start at the first wrap, with the next pulse exactly 1,083,264 cycles later.
- Duty counts over a full frame: hsync-high cycles = 136*806 = 109,616; vsync-high cycles = 8064; cycles with hblnk|vblnk = 1,083,264 - 1024*768 = 296,832.
